// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions. It holds the FSM state encoding, the
//               default CLK_DIV and DATA_BITS values, and a parity helper.
//               The TX engine and the RX side both import this package.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default clk cycles per bit.
  localparam int CLK_DIV_DEF   = 16;
  // Default payload bits per frame.
  localparam int DATA_BITS_DEF = 8;

  // Frame state machine encoding. The width is explicit so that the RX side
  // can reuse the same encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Parity over a payload that is zero-extended to 8 bits. The padding zeros
  // do not change the XOR, so any DATA_BITS from 5 to 8 can use it.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter. It counts 0..CLK_DIV-1 and wraps. tick is
//               high during the last cycle of each bit period. clear holds
//               the count at 0 and masks tick, which lets a frame start on
//               an exact bit boundary. The RX side also uses this block.
// Revision    : 1.0 - initial release
// Ports       : clk   - system clock
//               rst   - asynchronous reset, active low
//               clear - hold the counter at 0 (suppresses tick)
//               tick  - last cycle of the current bit period
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX) && !clear;

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine
// Description : UART transmit engine. It accepts one payload word through a
//               valid/ready handshake and serialises it as
//               START, DATA (LSB first), optional PARITY, and 1 or 2 STOP bits.
//               Each bit lasts CLK_DIV clk cycles.
// Revision    : 1.0 - initial release
// Config      : UART_TX_PARITY_EN - when defined, the engine sends a parity
//               bit after the data bits (par_odd selects odd parity). When
//               undefined, there is no parity logic and par_odd is ignored.
// Ports       : clk      - system clock
//               rst      - asynchronous reset, active low
//               tx_data  - payload word offered upstream
//               tx_valid - tx_data valid
//               tx_ready - engine idle, can accept a word
//               stop2    - 1 = two stop bits, 0 = one stop bit
//               par_odd  - 1 = odd parity, 0 = even parity
//               txd      - serial line (idle high, driven straight from a flop)
//               busy     - frame in progress
//               tx_done  - single-cycle pulse on the first idle cycle
// ============================================================================
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 stop2,
  input  logic                 par_odd,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop2_q, stop2_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 baud_clear;
  logic                 baud_tick;

`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`else
  logic                 unused_par_odd;
  assign unused_par_odd = par_odd;
`endif

  // The counter is held at 0 while idle. The first tick after an accept
  // therefore ends a full-length START bit.
  assign baud_clear = (state_q == IDLE);

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  // Next-state and next-output logic. All outputs are registered with
  // state_q, so txd has no combinational path from any input.
  always_comb begin
    state_d   = state_q;
    txd_d     = txd_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    shift_d   = shift_q;
    stop2_d   = stop2_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        // ready_q is high in IDLE, so tx_valid alone completes the handshake.
        if (tx_valid) begin
          state_d   = START;
          txd_d     = 1'b0;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
          shift_d   = tx_data;
          stop2_d   = stop2;
          bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d  = calc_parity(8'(tx_data), par_odd);
`endif
        end
      end

      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 3'd0;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            txd_d     = parity_q;
`else
            state_d   = STOP;
            txd_d     = 1'b1;
`endif
          end else begin
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d   = STOP;
          txd_d     = 1'b1;
          bit_cnt_d = 3'd0;
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          // bit_cnt_q counts stop bits. A second period is added only for
          // the captured stop2 setting.
          if (stop2_q && (bit_cnt_q == 3'd0)) begin
            bit_cnt_d = 3'd1;
          end else begin
            state_d   = IDLE;
            txd_d     = 1'b1;
            busy_d    = 1'b0;
            ready_d   = 1'b1;
            done_d    = 1'b1;
            bit_cnt_d = 3'd0;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        txd_d     = 1'b1;
        busy_d    = 1'b0;
        ready_d   = 1'b1;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      shift_q   <= '0;
      stop2_q   <= 1'b0;
      bit_cnt_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      shift_q   <= shift_d;
      stop2_q   <= stop2_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;

endmodule : uart_tx_engine
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_engine
// Description : Scoreboard bench for uart_tx_engine with CLK_DIV=4 and
//               DATA_BITS=8. The stimulus side pushes the expected frame on
//               each accept. A monitor decodes txd on the falling edge and
//               compares it against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

  localparam int CLK_DIV   = 4;
  localparam int DATA_BITS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       stop2;
  logic       par_odd;
  logic       txd;
  logic       busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_done = 0;
  bit mon_busy  = 1'b0;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    bit          abort;
    int          gap;       // cycles from the previous tx_done sample, -1 = any
    int          start_at;  // absolute cycle of the start sample, -1 = any
    logic [7:0]  data;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_engine #(
    .CLK_DIV   (CLK_DIV),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .stop2    (stop2),
    .par_odd  (par_odd),
    .txd      (txd),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  // Expected line pattern: start, data LSB first, optional parity, then stops.
  // The vector table supplies the parity bit.
  function automatic exp_t mk(input logic [7:0] d, input logic s2, input logic pbit);
    exp_t e;
    int   n;
    e.bits = '0;
    e.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
    n = 9;
`ifdef UART_TX_PARITY_EN
    e.bits[n] = pbit;
    n++;
`else
    if (pbit) n = n + 0;
`endif
    e.bits[n] = 1'b1;
    n++;
    if (s2) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.nbits    = n;
    e.abort    = 1'b0;
    e.gap      = -1;
    e.start_at = -1;
    e.data     = d;
    return e;
  endfunction

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 200);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: tx_ready=%b after %0d cycles, want 1", tx_ready, t);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s2, input logic po,
                      input logic pbit, input bit ab);
    bit   ok;
    exp_t e;
    @(negedge clk);
    tx_data  = d;
    stop2    = s2;
    par_odd  = po;
    tx_valid = 1'b1;
    wait_ready(ok);
    if (ok) begin
      e = mk(d, s2, pbit);
      e.abort = ab;
      q.push_back(e);
      @(posedge clk);
    end
    // Scramble the inputs after the accept. The frame must be unaffected.
    #1;
    tx_valid = 1'b0;
    tx_data  = ~d;
    stop2    = ~s2;
    par_odd  = ~po;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t e;
    bit   aborted;
    bit   ok;
    logic g_txd, g_busy, g_rdy, g_done;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txd === 1'b0) begin
        mon_busy = 1'b1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, want none", cyc);
          for (int t = 0; t < 200 && busy === 1'b1; t++) @(negedge clk);
          mon_busy = 1'b0;
          continue;
        end
        e = q.pop_front();
        if (e.start_at >= 0) begin
          checks++;
          if (cyc != e.start_at) begin
            errors++;
            $display("FAIL start_latency: start at cycle %0d, want %0d", cyc, e.start_at);
          end
        end
        if (e.gap >= 0) begin
          checks++;
          if (cyc - last_done != e.gap) begin
            errors++;
            $display("FAIL frame_gap: %0d cycles after tx_done, want %0d", cyc - last_done, e.gap);
          end
        end
        aborted = 1'b0;
        for (int k = 0; k < e.nbits && !aborted; k++) begin
          ok = 1'b1;
          g_txd = 1'b0; g_busy = 1'b0; g_rdy = 1'b0; g_done = 1'b0;
          for (int j = 0; j < CLK_DIV && !aborted; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (rst !== 1'b1) begin
              aborted = 1'b1;
            end else if (txd !== e.bits[k] || busy !== 1'b1 ||
                         tx_ready !== 1'b0 || tx_done !== 1'b0) begin
              if (ok) begin
                g_txd = txd; g_busy = busy; g_rdy = tx_ready; g_done = tx_done;
              end
              ok = 1'b0;
            end
          end
          if (!aborted) begin
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL frame_bit data=%02h bit=%0d: got txd=%b busy=%b ready=%b done=%b, want txd=%b busy=1 ready=0 done=0",
                       e.data, k, g_txd, g_busy, g_rdy, g_done, e.bits[k]);
            end
          end
        end
        if (aborted) begin
          checks++;
          if (!e.abort) begin
            errors++;
            $display("FAIL unexpected_reset: frame data=%02h cut short", e.data);
          end else if (txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got txd=%b busy=%b ready=%b done=%b, want 1 0 1 0",
                     txd, busy, tx_ready, tx_done);
          end
          for (int t = 0; t < 100 && rst !== 1'b1; t++) @(negedge clk);
        end else begin
          if (e.abort) begin
            checks++;
            errors++;
            $display("FAIL reset_missing: frame data=%02h finished, want abort", e.data);
          end
          @(negedge clk);
          checks++;
          if (tx_done !== 1'b1 || busy !== 1'b0 || txd !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_end data=%02h: got done=%b busy=%b txd=%b ready=%b, want 1 0 1 1",
                     e.data, tx_done, busy, txd, tx_ready);
          end
          last_done = cyc;
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Vectors: data, stop2, par_odd, hand-computed parity bit.
  logic [7:0] v_data [6] = '{8'hA5, 8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80};
  logic       v_s2   [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
  logic       v_po   [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
  logic       v_par  [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};

  initial begin : stim
    exp_t e;
    bit   ok;
    int   t;
    rst      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    stop2    = 1'b0;
    par_odd  = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got txd=%b busy=%b ready=%b done=%b, want 1 0 1 0",
               txd, busy, tx_ready, tx_done);
    end

    // Release the reset with a word already offered. The accept must happen
    // on the first rising edge.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    e = mk(8'hA5, 1'b0, 1'b0);
    e.start_at = cyc + 1;
    q.push_back(e);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'h5A;

    for (int i = 0; i < 6; i++) send(v_data[i], v_s2[i], v_po[i], v_par[i], 1'b0);

    // Back to back with tx_valid held high. The second word must start
    // exactly one idle cycle after tx_done.
    @(negedge clk);
    tx_data  = 8'h11;
    stop2    = 1'b0;
    par_odd  = 1'b0;
    tx_valid = 1'b1;
    wait_ready(ok);
    if (ok) begin
      q.push_back(mk(8'h11, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      tx_data = 8'h22;
      @(negedge clk);
      wait_ready(ok);
      if (ok) begin
        e = mk(8'h22, 1'b0, 1'b0);
        e.gap = 1;
        q.push_back(e);
        @(posedge clk);
      end
    end
    #1;
    tx_valid = 1'b0;

    // Assert the asynchronous reset during data bit 3, then send a full frame.
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (16) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    t = 0;
    while ((q.size() != 0 || mon_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d frames outstanding, want 0", q.size());
    end
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_engine
`default_nettype wire
